// File: rtl/tick_bcd_counter.sv
`default_nettype none
// tick_bcd_counter: rising edge of the divider tick steps a DIGITS-wide BCD up/down counter under start/stop/clear control.
// Optional PAUSE-state parallel load is enabled by defining TICK_BCD_LOAD_EN.
module tick_bcd_counter #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick_in,
   input  logic                start,
   input  logic                stop,
   input  logic                clear,
   input  logic                up_dn,
`ifdef TICK_BCD_LOAD_EN
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
`endif
   output logic [4*DIGITS-1:0] bcd,
   output logic                carry_out,
   output logic                running
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_t1;
   logic                r_t2;
   logic                w_step;
   logic [4*DIGITS-1:0] r_bcd;
   logic [4*DIGITS-1:0] w_bcd_nxt;
   logic [4*DIGITS-1:0] w_bcd_stepped;
   logic [4*DIGITS-1:0] w_load_sat;
   logic                w_load;
   logic                w_wrap;
   logic                r_carry;
   logic                w_carry_nxt;

   assign w_step = r_t1 & ~r_t2;

`ifdef TICK_BCD_LOAD_EN
   assign w_load = load;
   // Out-of-range load digits clamp to 9 so the counter never holds invalid BCD.
   always_comb begin
      w_load_sat = load_val;
      for (int i = 0; i < DIGITS; i++) begin
         if (load_val[4*i +: 4] > 4'd9) begin
            w_load_sat[4*i +: 4] = 4'd9;
         end
      end
   end
`else
   assign w_load     = 1'b0;
   assign w_load_sat = '0;
`endif

   // Ripple increment/decrement; w_wrap is the carry/borrow out of the top digit.
   always_comb begin
      logic       c;
      logic [3:0] d;
      c             = 1'b1;
      d             = 4'd0;
      w_bcd_stepped = r_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         d = r_bcd[4*i +: 4];
         if (c) begin
            if (up_dn) begin
               if (d == 4'd9) begin
                  w_bcd_stepped[4*i +: 4] = 4'd0;
               end else begin
                  w_bcd_stepped[4*i +: 4] = d + 4'd1;
                  c = 1'b0;
               end
            end else begin
               if (d == 4'd0) begin
                  w_bcd_stepped[4*i +: 4] = 4'd9;
               end else begin
                  w_bcd_stepped[4*i +: 4] = d - 4'd1;
                  c = 1'b0;
               end
            end
         end
      end
      w_wrap = c;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_bcd_nxt   = r_bcd;
      w_carry_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_bcd_nxt = '0;
            if (!clear && !stop && start) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (clear) begin
               w_state_nxt = S_IDLE;
               w_bcd_nxt   = '0;
            end else if (stop) begin
               w_state_nxt = S_PAUSE;
            end else if (w_step) begin
               w_bcd_nxt   = w_bcd_stepped;
               w_carry_nxt = w_wrap;
            end
         end
         S_PAUSE: begin
            if (clear) begin
               w_state_nxt = S_IDLE;
               w_bcd_nxt   = '0;
            end else if (stop) begin
               w_state_nxt = S_PAUSE;
            end else if (start) begin
               w_state_nxt = S_RUN;
            end else if (w_load) begin
               w_bcd_nxt = w_load_sat;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_bcd_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_t1    <= 1'b0;
         r_t2    <= 1'b0;
         r_bcd   <= '0;
         r_carry <= 1'b0;
      end else begin
         r_t1    <= tick_in;
         r_t2    <= r_t1;
         r_bcd   <= w_bcd_nxt;
         r_carry <= w_carry_nxt;
      end
   end

   assign bcd       = r_bcd;
   assign carry_out = r_carry;
   assign running   = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: doc/tick_bcd_counter.md
Name: tick_bcd_counter

Overview:
- Downstream consumer of the free-running divider's level output `tick`. That output is high for the upper half of the divider count.
- The block registers that level and detects its rising edge, producing one step per divider period.
- Each step advances a DIGITS-wide BCD up/down counter, gated by a start/stop/clear control FSM.
- Feeds the seven-segment display mux and any stopwatch/timer logic.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); count range 0 .. 10^DIGITS-1

Ports:
- clk        in   1          system clock; same domain as the divider
- rst        in   1          asynchronous, active-high reset
- tick_in    in   1          divider level output; may be combinational, so it is registered before use
- start      in   1          run request; synchronous level, sampled each edge
- stop       in   1          pause request
- clear      in   1          return to IDLE and zero the count
- up_dn      in   1          1 = count up, 0 = count down; sampled on each step
- bcd        out  4*DIGITS   digit i at bits [4i+3:4i]; digit 0 is least significant
- carry_out  out  1          one-cycle pulse on wrap (up) or borrow (down)
- running    out  1          high while the FSM is in RUN

Behaviour:
- Reset (rst=1, asynchronous):
  - t1=0, t2=0; state=IDLE; bcd=0; carry_out=0; running=0.
- Edge detect:
  - t1<=tick_in; t2<=t1; step = t1 & ~t2 (combinational).
  - Edge E0 is the first clk edge that samples tick_in=1. step is high for exactly one cycle, between E0 and E1. bcd updates at E1.
  - Latency from sampled tick_in rise to bcd change: 1 clk.
  - tick_in held high for any length gives one step only. tick_in high for 1 cycle still gives one step.
- FSM states:
  - IDLE: bcd forced to 0; start -> RUN.
  - RUN: count on step; stop -> PAUSE; clear -> IDLE.
  - PAUSE: bcd held; start -> RUN; clear -> IDLE.
- Priority per edge: clear > stop > start. clear in RUN or PAUSE zeroes bcd at that edge. clear in IDLE has no effect.
- Step arrives in the same edge as a transition out of RUN: the step is discarded.
- Step arrives in the same edge as IDLE->RUN or PAUSE->RUN: the step is discarded; counting begins with the next step.
- running = (state==RUN); registered, so it changes at the same edge as the state.
- Up count (up_dn=1):
  - digit 0 increments. A digit at 9 goes to 0 and carries into the next digit, ripple within one cycle.
  - All digits 9 -> all 0, and carry_out=1 for the next cycle.
- Down count (up_dn=0):
  - a digit at 0 goes to 9 and borrows from the next digit.
  - All 0 -> all 9, and carry_out=1.
- carry_out:
  - registered, high exactly one cycle after a wrapping step, else 0.
  - Never asserted by clear, load or reset.
- Digits always hold 0..9; no invalid BCD is reachable.
- Reset mid-count: immediate return to the reset values. The first tick_in rise after reset release counts only once start has been asserted.

Optional Feature:
- Macro: TICK_BCD_LOAD_EN.
- When defined, two extra ports are added:
  - load, in, 1
  - load_val, in, 4*DIGITS
- In PAUSE, load=1 copies load_val into bcd at the next edge.
  - Any load_val digit >9 is stored as 9.
  - clear and stop take priority over load.
  - load in IDLE or RUN is ignored.
  - load never pulses carry_out.
- When undefined, the ports are absent and the behaviour is as above.

Test Plan:
- Reset values: rst pulse mid-cycle with tick_in toggling -> bcd=0, running=0 and carry_out=0 immediately; state IDLE; no count until start is asserted.
- Single step and latency: DIGITS=4, start then 3 tick_in rises -> bcd=0x0003. Each change lands 1 clk after the edge sampling tick_in=1. tick_in held high for 20 cycles gives +1 only.
- Up wrap: DIGITS=2, count to 0x99 then one more step -> bcd=0x00, carry_out high exactly 1 cycle. 0x09 -> 0x10 on the intermediate step.
- Down borrow: DIGITS=2, up_dn=0 from 0x10 -> 0x09; from 0x00 -> 0x99 with a carry_out pulse.
- Control priority: in RUN at 0x0042, stop+clear in the same cycle -> IDLE, bcd=0. Step coincident with stop -> PAUSE with bcd unchanged. start from PAUSE resumes from the held value.
- (TICK_BCD_LOAD_EN) In PAUSE, load with load_val=0x0A59 -> bcd=0x0959. load in RUN -> ignored. Next start plus step -> 0x0960.
